shift_sequencer: RTL and testbench

//  Command front-end directly upstream of the universal shift register stage
//  (per-bit mux; mode inputs l/r, serial fill i, parallel load d, state q).

---
 rtl/shift_sequencer_if.sv | 25 ++
 rtl/shift_sequencer.sv | 106 ++++++++++
 tb/tb_shift_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command handshake and completion bundle for shift_sequencer
interface shift_sequencer_if #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_fill;
  logic [W-1:0]  cmd_data;
  logic          done;
  logic          err;
  logic [W-1:0]  res;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data,
    input  cmd_ready, done, err, res
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data,
    output cmd_ready, done, err, res
  );
endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences load/shift/rotate commands onto a universal shift register
module shift_sequencer #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic            c,
  input  logic            rst,
  shift_sequencer_if.slave cmd,
  output logic            l,
  output logic            r,
  output logic            i,
  output logic [W-1:0]    d,
  input  logic [W-1:0]    q
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;
  localparam logic [CW-1:0] REM_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic          fill_q, fill_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          err_q, err_d;
  logic          illegal;

  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      fill_q  <= 1'b0;
      data_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign illegal = (cmd.cmd_op > OP_ASR);
  assign d       = data_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    fill_d        = fill_q;
    data_d        = data_q;
    rem_d         = rem_q;
    err_d         = err_q;
    cmd.cmd_ready = 1'b0;
    cmd.done      = 1'b0;
    cmd.err       = 1'b0;
    cmd.res       = '0;
    l             = 1'b0;
    r             = 1'b0;
    i             = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          op_d    = cmd.cmd_op;
          fill_d  = cmd.cmd_fill;
          data_d  = cmd.cmd_data;
          rem_d   = (cmd.cmd_op == OP_LOAD) ? REM_ONE : cmd.cmd_cnt;
          err_d   = illegal;
          // Zero-count and illegal commands skip RUN so the register is never touched.
          state_d = (rem_d != '0 && !illegal) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        case (op_q)
          OP_LOAD: begin l = 1'b1; r = 1'b1; end
          OP_SHL:  begin r = 1'b1; i = fill_q; end
          OP_ROL:  begin r = 1'b1; i = q[W-1]; end
          OP_SHR:  begin l = 1'b1; i = fill_q; end
          OP_ROR:  begin l = 1'b1; i = q[0]; end
          OP_ASR:  begin l = 1'b1; i = q[W-1]; end
          default: begin l = 1'b0; r = 1'b0; end
        endcase
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cmd.done = 1'b1;
        cmd.err  = err_q;
        cmd.res  = q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed bench for shift_sequencer against a behavioural model
module tb_shift_sequencer;
  logic       c = 1'b0;
  logic       rst = 1'b1;
  logic       sr_l, sr_r, sr_i;
  logic [7:0] sr_d;
  logic [7:0] q_reg = 8'h00;

  int tests = 0;
  int fails = 0;

  shift_sequencer_if #(.W(8)) bus ();

  shift_sequencer #(.W(8)) dut (
    .c   (c),
    .rst (rst),
    .cmd (bus.slave),
    .l   (sr_l),
    .r   (sr_r),
    .i   (sr_i),
    .d   (sr_d),
    .q   (q_reg)
  );

  always #5 c = ~c;

  // Universal shift register stage the sequencer drives.
  always @(posedge c) begin
    case ({sr_l, sr_r})
      2'b01:   q_reg <= {q_reg[6:0], sr_i};
      2'b10:   q_reg <= {sr_i, q_reg[7:1]};
      2'b11:   q_reg <= sr_d;
      default: q_reg <= q_reg;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_res(input logic [2:0] op, input logic [7:0] qv,
                                           input int cnt, input logic fill, input logic [7:0] data);
    int v, s;
    v = qv;
    case (op)
      3'd0: return data;
      3'd1: return 8'(((v << cnt) | (fill ? ((1 << cnt) - 1) : 0)) & 255);
      3'd2: return 8'(((v >> cnt) | (fill ? (255 & ~(255 >> cnt)) : 0)) & 255);
      3'd3: return 8'(((v << cnt) | (v >> (8 - cnt))) & 255);
      3'd4: return 8'(((v >> cnt) | (v << (8 - cnt))) & 255);
      3'd5: begin
        s = (v >= 128) ? v - 256 : v;
        return 8'((s >>> cnt) & 255);
      end
      default: return qv;
    endcase
  endfunction

  function automatic int run_len(input logic [2:0] op, input int cnt);
    if (op == 3'd0) return 1;
    if (op <= 3'd5) return cnt;
    return 0;
  endfunction

  function automatic logic [1:0] lr_of(input logic [2:0] op);
    if (op == 3'd0) return 2'b11;
    if (op == 3'd1 || op == 3'd3) return 2'b01;
    return 2'b10;
  endfunction

  // Model state, expressed as absolute cycle numbers of the command in flight.
  bit         mon_en = 0;
  int         cyc = 0;
  bit         busy = 0;
  int         acc_cyc, m_len, rel;
  logic [2:0] m_op;
  logic       m_fill, m_err;
  logic [7:0] m_res, d_exp = 8'h00;
  int         acc_count = 0, done_count = 0, last_lat = 0;
  logic [7:0] last_res;
  logic       last_err;
  bit         exp_ready, exp_done, in_run;
  logic [1:0] exp_lr;

  always @(negedge c) begin
    if (mon_en) begin
      cyc++;
      exp_ready = 1'b1;
      exp_done  = 1'b0;
      in_run    = 1'b0;
      exp_lr    = 2'b00;
      if (busy) begin
        rel = cyc - acc_cyc;
        if (rel <= m_len) begin
          exp_ready = 1'b0;
          exp_lr    = lr_of(m_op);
          in_run    = 1'b1;
        end else if (rel == m_len + 1) begin
          exp_ready = 1'b0;
          exp_done  = 1'b1;
        end
      end
      chk("cmd_ready", bus.cmd_ready, exp_ready);
      chk("lr", {sr_l, sr_r}, exp_lr);
      chk("done", bus.done, exp_done);
      chk("d", sr_d, d_exp);
      if (exp_done) begin
        chk("res", bus.res, m_res);
        chk("err", bus.err, m_err);
        last_res = bus.res;
        last_err = bus.err;
        last_lat = rel;
        done_count++;
        busy = 0;
      end else begin
        chk("err_idle", bus.err, 1'b0);
        chk("res_idle", bus.res, 8'h00);
      end
      if (in_run && (m_op == 3'd1 || m_op == 3'd2))
        chk("fill_i", sr_i, m_fill);
      if (rst) begin
        busy  = 0;
        d_exp = 8'h00;
      end else if (bus.cmd_valid && exp_ready) begin
        busy    = 1;
        acc_cyc = cyc;
        m_op    = bus.cmd_op;
        m_fill  = bus.cmd_fill;
        m_len   = run_len(bus.cmd_op, int'(bus.cmd_cnt));
        m_err   = (bus.cmd_op > 3'd5);
        m_res   = model_res(bus.cmd_op, q_reg, int'(bus.cmd_cnt), bus.cmd_fill, bus.cmd_data);
        d_exp   = bus.cmd_data;
        acc_count++;
      end
    end
  end

  task automatic scramble();
    bus.cmd_op   = 3'($urandom_range(0, 7));
    bus.cmd_cnt  = 3'($urandom_range(0, 7));
    bus.cmd_fill = 1'($urandom_range(0, 1));
    bus.cmd_data = 8'($urandom_range(0, 255));
  endtask

  // Called and returns at posedge+2; returns in the cycle after the accept edge.
  task automatic issue(input logic [2:0] op, input int cnt, input logic fill, input logic [7:0] data);
    bit ok;
    ok = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = 3'(cnt);
    bus.cmd_fill  = fill;
    bus.cmd_data  = data;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge c);
      if (bus.cmd_ready && !rst) ok = 1;
      @(posedge c); #2;
    end
    bus.cmd_valid = 1'b0;
    scramble();
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge c);
      if (bus.done) got = 1;
      @(posedge c); #2;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run_cmd(input logic [2:0] op, input int cnt, input logic fill, input logic [7:0] data);
    issue(op, cnt, fill, data);
    wait_done();
  endtask

  int         a0, d0;
  logic [7:0] q0;

  initial begin
    bus.cmd_valid = 1'b0;
    scramble();
    repeat (2) @(posedge c);
    #2;
    chk("rst_ready", bus.cmd_ready, 1'b1);
    chk("rst_lr", {sr_l, sr_r}, 2'b00);
    chk("rst_i", sr_i, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_res", bus.res, 8'h00);
    chk("rst_d", sr_d, 8'h00);
    mon_en = 1;
    @(posedge c); #2;
    rst = 1'b0;

    run_cmd(3'd0, 5, 1'b0, 8'hA5);
    chk("t1_res", last_res, 8'hA5);
    chk("t1_err", last_err, 1'b0);
    chk("t1_lat", last_lat, 2);

    run_cmd(3'd0, 0, 1'b0, 8'h81);
    run_cmd(3'd1, 3, 1'b1, 8'h00);
    chk("t2_res", last_res, 8'h0F);
    chk("t2_lat", last_lat, 4);

    run_cmd(3'd0, 0, 1'b0, 8'h01);
    run_cmd(3'd4, 1, 1'b0, 8'h00);
    chk("t3_ror", last_res, 8'h80);
    run_cmd(3'd3, 7, 1'b0, 8'h00);
    chk("t3_rol", last_res, 8'h40);
    chk("t3_lat", last_lat, 8);

    run_cmd(3'd0, 0, 1'b0, 8'h90);
    run_cmd(3'd5, 2, 1'b0, 8'h00);
    chk("t4_asr", last_res, 8'hE4);
    run_cmd(3'd2, 0, 1'b1, 8'h00);
    chk("t4_shr0", last_res, 8'hE4);
    chk("t4_lat", last_lat, 1);

    a0 = acc_count; d0 = done_count; q0 = q_reg;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd7; bus.cmd_cnt = 3'd5; bus.cmd_fill = 1'b1; bus.cmd_data = 8'h3C;
    repeat (4) @(posedge c);
    #2;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge c);
    #2;
    chk("t5_accepts", acc_count - a0, 2);
    chk("t5_dones", done_count - d0, 2);
    chk("t5_err", last_err, 1'b1);
    chk("t5_lat", last_lat, 1);
    chk("t5_q", q_reg, q0);

    run_cmd(3'd0, 0, 1'b0, 8'hFF);
    d0 = done_count;
    issue(3'd1, 7, 1'b0, 8'h00);
    @(posedge c); #2;
    @(posedge c); #2;
    rst = 1'b1;
    @(posedge c); #2;
    rst = 1'b0;
    @(negedge c);
    chk("t6_ready", bus.cmd_ready, 1'b1);
    chk("t6_lr", {sr_l, sr_r}, 2'b00);
    @(posedge c); #2;
    repeat (10) @(posedge c);
    #2;
    chk("t6_nodone", done_count - d0, 0);
    chk("t6_q", q_reg, 8'hF8);

    for (int n = 0; n < 250; n++) begin
      run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(posedge c);
      #0;
    end

    repeat (3) @(posedge c);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
